// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, runs the req/ack handshake with instruction
// memory and feeds the IF/ID register, honouring redirects, stalls and flushes.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    input  logic        JumpD,
    input  logic [31:0] PCJumpD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] cmd,
    output logic [31:0] PCPlusFourD,
    output logic        ValidD
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic        req_q;
    logic [31:0] cmd_q, cmd_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;

    logic        redirect_s;
    logic [31:0] target_s;
    logic        ack_s;
    logic [31:0] pc_plus4_s;
    logic [31:0] ld_cmd_s;
    logic [31:0] ld_pc4_s;
    logic        ld_valid_s;

    // Jump wins over branch; targets are word-aligned by dropping the low bits.
    assign redirect_s = PCSrcD | JumpD;
    assign target_s   = (JumpD ? PCJumpD : PCBranchD) & 32'hFFFF_FFFC;
    assign ack_s      = imem_ack & req_q;
    assign pc_plus4_s = pc_q + 32'd4;

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign cmd         = cmd_q;
    assign PCPlusFourD = pc4_q;
    assign ValidD      = valid_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN, S_WAIT: begin
                if (!req_q) begin
                    state_d = state_q;
                end else if (ack_s) begin
                    state_d = S_RUN;
                end else if (redirect_s) begin
                    state_d = S_DROP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DROP: begin
                if (ack_s) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_DROP;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    // Datapath: PC / pending target update and IF/ID load value.
    always_comb begin
        pc_d       = pc_q;
        tgt_d      = tgt_q;
        ld_cmd_s   = NOP_INSTR;
        ld_pc4_s   = 32'h0000_0000;
        ld_valid_s = 1'b0;
        if (!req_q) begin
            pc_d = pc_q;
        end else if (state_q == S_DROP) begin
            // A redirect arriving while dropping replaces the pending target.
            if (redirect_s) begin
                tgt_d = target_s;
            end else begin
                tgt_d = tgt_q;
            end
            if (ack_s) begin
                pc_d = redirect_s ? target_s : tgt_q;
            end else begin
                pc_d = pc_q;
            end
        end else if (ack_s) begin
            if (redirect_s) begin
                pc_d = target_s;
            end else if (StallF) begin
                pc_d = pc_q;
            end else begin
                pc_d       = pc_plus4_s;
                ld_cmd_s   = imem_rdata;
                ld_pc4_s   = pc_plus4_s;
                ld_valid_s = 1'b1;
            end
        end else if (redirect_s) begin
            tgt_d = target_s;
        end else begin
            tgt_d = tgt_q;
        end

        if (FlushD) begin
            cmd_d   = NOP_INSTR;
            pc4_d   = 32'h0000_0000;
            valid_d = 1'b0;
        end else if (StallD) begin
            cmd_d   = cmd_q;
            pc4_d   = pc4_q;
            valid_d = valid_q;
        end else begin
            cmd_d   = ld_cmd_s;
            pc4_d   = ld_pc4_s;
            valid_d = ld_valid_s;
        end
    end

    // PC, pending target, request and IF/ID registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            tgt_q   <= RESET_PC;
            req_q   <= 1'b0;
            cmd_q   <= NOP_INSTR;
            pc4_q   <= 32'h0000_0000;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            req_q   <= 1'b1;
            cmd_q   <= cmd_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a driver feeds stimulus and a fetch model,
// pushing expectations; a monitor pops and compares once per cycle.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0;
    logic        PCSrcD = 1'b0, JumpD = 1'b0;
    logic [31:0] PCBranchD = 32'h0, PCJumpD = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] cmd, PCPlusFourD;
    logic        ValidD;

    if_stage dut (
        .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcD(PCSrcD), .PCBranchD(PCBranchD), .JumpD(JumpD), .PCJumpD(PCJumpD),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .cmd(cmd), .PCPlusFourD(PCPlusFourD), .ValidD(ValidD)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] cmd;
        logic [31:0] pc4;
        logic        valid;
        logic [31:0] addr;
        logic        req;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Fetch model: where the next fetch happens, whether its data is wrong-path,
    // where to go once it completes, and what decode currently holds.
    logic [31:0] m_pc, m_tgt, m_cmd, m_pc4;
    logic        m_drop, m_req, m_valid;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_tgt = 32'h0; m_drop = 1'b0; m_req = 1'b0;
        m_cmd = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        exp_q.delete();
    endtask

    // One clock cycle of stimulus plus the model's view of its outcome.
    task automatic step(input bit ack, input bit sf, input bit sd, input bit fd,
                        input bit br, input logic [31:0] bt, input bit jp, input logic [31:0] jt);
        logic [31:0] tgt, n_cmd, n_pc4;
        logic        redir, n_valid, take;
        exp_t        e;
        @(negedge clk);
        take       = ack & m_req;
        StallF     = sf; StallD = sd; FlushD = fd;
        PCSrcD     = br; PCBranchD = bt; JumpD = jp; PCJumpD = jt;
        imem_ack   = take;
        imem_rdata = memw(imem_addr);

        redir   = br | jp;
        tgt     = (jp ? jt : bt) & 32'hFFFF_FFFC;
        n_cmd   = 32'h0; n_pc4 = 32'h0; n_valid = 1'b0;
        if (m_req) begin
            if (m_drop) begin
                if (redir) m_tgt = tgt;
                if (take) begin
                    m_pc   = m_tgt;
                    m_drop = 1'b0;
                end
            end else if (take) begin
                if (redir) m_pc = tgt;
                else if (!sf) begin
                    n_cmd   = memw(m_pc);
                    n_pc4   = m_pc + 32'd4;
                    n_valid = 1'b1;
                    m_pc    = m_pc + 32'd4;
                end
            end else if (redir) begin
                m_tgt  = tgt;
                m_drop = 1'b1;
            end
        end
        if (fd) begin
            m_cmd = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (!sd) begin
            m_cmd = n_cmd; m_pc4 = n_pc4; m_valid = n_valid;
        end
        m_req = 1'b1;
        e.cmd = m_cmd; e.pc4 = m_pc4; e.valid = m_valid; e.addr = m_pc; e.req = m_req;
        exp_q.push_back(e);
    endtask

    task automatic go(input bit ack);
        step(ack, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    // Asynchronous reset mid-cycle, checked immediately, then released on a negedge.
    task automatic do_reset();
        @(negedge clk);
        imem_ack = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
        PCSrcD = 1'b0; JumpD = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_cmd", cmd, 32'h0);
        chk("rst_pc4", PCPlusFourD, 32'h0);
        chk("rst_valid", {31'h0, ValidD}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compare DUT outputs against the oldest expectation each cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("cmd", cmd, e.cmd);
                chk("pc4", PCPlusFourD, e.pc4);
                chk("valid", {31'h0, ValidD}, {31'h0, e.valid});
                chk("addr", imem_addr, e.addr);
                chk("req", {31'h0, imem_req}, {31'h0, e.req});
                if (ValidD === 1'b1) chk("word_vs_pc", cmd, memw(PCPlusFourD - 32'd4));
            end
        end
    end

    initial begin
        bit a, sf, sd, fd, br, jp;
        model_reset();
        do_reset();
        go(1'b0);                                  // first cycle after reset: req rises
        repeat (4) go(1'b1);                       // 0x0..0xC, zero-wait
        go(1'b0); go(1'b0); go(1'b1);              // 0x10 acked 2 cycles late
        step(1'b1, 0, 0, 0, 1'b1, 32'h40, 1'b0, 32'h0);     // branch with ack
        go(1'b1);
        step(1'b1, 0, 0, 0, 1'b1, 32'h40, 1'b1, 32'h100);   // jump beats branch
        go(1'b1);
        go(1'b0);                                           // enter WAIT
        step(1'b0, 0, 0, 0, 1'b1, 32'h80, 1'b0, 32'h0);     // redirect in WAIT -> DROP
        go(1'b0); go(1'b0); go(1'b1);                       // late ack dropped
        go(1'b1);
        step(1'b1, 1'b1, 1'b1, 0, 0, 32'h0, 0, 32'h0);      // full stall x2
        step(1'b1, 1'b1, 1'b1, 0, 0, 32'h0, 0, 32'h0);
        go(1'b1);
        step(1'b1, 0, 0, 1'b1, 0, 32'h0, 0, 32'h0);         // flush
        step(1'b1, 0, 0, 0, 0, 32'h0, 1'b1, 32'hFFFF_FFFF); // jump to 0xFFFFFFFC
        go(1'b1); go(1'b1);                                 // wrap to 0
        go(1'b0);                                           // WAIT, then reset
        do_reset();
        go(1'b0);
        for (int i = 0; i < 3000; i++) begin
            a  = ($urandom_range(0, 99) < 55);
            sf = ($urandom_range(0, 99) < 12);
            sd = ($urandom_range(0, 99) < 12);
            fd = ($urandom_range(0, 99) < 8);
            br = ($urandom_range(0, 99) < 8);
            jp = ($urandom_range(0, 99) < 5);
            step(a, sf, sd, fd, br, $urandom, jp, $urandom);
        end
        @(negedge clk);
        imem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
